// File: rtl/count_checker.sv
// rtl/count_checker.sv - lock/flywheel monitor for a mod-2^WIDTH counter bus
// Optional latched error flag built only when COUNT_CHECKER_STICKY_EN is defined.
module count_checker #(
    parameter int WIDTH    = 2,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] val,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic             err_sticky
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_LAST = 4'(MISS_MAX);

    state_t           state, state_nx;
    logic             prev_vld, prev_vld_nx;
    logic [3:0]       run, run_nx;
    logic [3:0]       miss, miss_nx;
    logic [WIDTH-1:0] exp_nx;
    logic [ERR_W-1:0] cnt_nx;
    logic             err_nx;
    logic             match;
    logic [WIDTH-1:0] val_inc;

    assign match   = (val == expected);
    assign val_inc = val + WIDTH'(1);
    assign locked  = (state == LOCKED);

    always_comb begin
        state_nx    = state;
        prev_vld_nx = prev_vld;
        run_nx      = run;
        miss_nx     = miss;
        exp_nx      = expected;
        cnt_nx      = err_count;
        err_nx      = 1'b0;
        if (en) begin
            if (state == HUNT) begin
                exp_nx = val_inc;
                if (!prev_vld) begin
                    prev_vld_nx = 1'b1;
                end else if (match) begin
                    if (run + 4'd1 == LOCK_LAST) begin
                        state_nx = LOCKED;
                        run_nx   = 4'd0;
                    end else begin
                        run_nx = run + 4'd1;
                    end
                end else begin
                    run_nx = 4'd0;
                end
            end else if (match) begin
                miss_nx = 4'd0;
                exp_nx  = expected + WIDTH'(1);
            end else begin
                // Flywheel: keep predicting from our own count, not from the bad sample.
                err_nx = 1'b1;
                if (err_count != {ERR_W{1'b1}})
                    cnt_nx = err_count + ERR_W'(1);
                if (miss + 4'd1 == MISS_LAST) begin
                    state_nx = HUNT;
                    run_nx   = 4'd0;
                    miss_nx  = 4'd0;
                    exp_nx   = val_inc;
                end else begin
                    miss_nx = miss + 4'd1;
                    exp_nx  = expected + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            state     <= HUNT;
            prev_vld  <= 1'b0;
            run       <= 4'd0;
            miss      <= 4'd0;
            expected  <= '0;
            err_count <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            prev_vld  <= prev_vld_nx;
            run       <= run_nx;
            miss      <= miss_nx;
            expected  <= exp_nx;
            err_count <= cnt_nx;
            err       <= err_nx;
        end
    end

`ifdef COUNT_CHECKER_STICKY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr)
            err_sticky <= 1'b0;
        else if (err_nx)
            err_sticky <= 1'b1;
    end
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking bench for count_checker (default and saturating configs)
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] val = 2'd0;

    logic       a_locked, a_err, a_sticky;
    logic [7:0] a_cnt;
    logic [1:0] a_exp;
    logic       b_locked, b_err, b_sticky;
    logic [1:0] b_cnt;
    logic [1:0] b_exp;

    int compared   = 0;
    int mismatched = 0;

    // Reference state per instance: 0 = default config, 1 = ERR_W=2, MISS_MAX=15
    int m_lock[2], m_pv[2], m_run[2], m_miss[2], m_exp[2], m_cnt[2], m_err[2], m_sticky[2];
    int ctr;

    always #5 clk = ~clk;

    count_checker dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .val(val),
        .locked(a_locked), .err(a_err), .err_count(a_cnt),
        .expected(a_exp), .err_sticky(a_sticky)
    );

    count_checker #(.WIDTH(2), .LOCK_CNT(4), .MISS_MAX(15), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .val(val),
        .locked(b_locked), .err(b_err), .err_count(b_cnt),
        .expected(b_exp), .err_sticky(b_sticky)
    );

    task automatic mreset(int i);
        m_lock[i] = 0; m_pv[i] = 0; m_run[i] = 0; m_miss[i] = 0;
        m_exp[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
    endtask

    task automatic mstep(int i, int miss_max, int cnt_max);
        int v;
        v = int'(val);
        m_err[i] = 0;
        if (clr) begin
            mreset(i);
        end else if (en) begin
            if (m_lock[i] == 0) begin
                if (m_pv[i] == 0) begin
                    m_pv[i] = 1;
                end else if (v == m_exp[i]) begin
                    m_run[i]++;
                    if (m_run[i] == 4) begin
                        m_lock[i] = 1;
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_exp[i] = (v + 1) % 4;
            end else if (v == m_exp[i]) begin
                m_miss[i] = 0;
                m_exp[i]  = (m_exp[i] + 1) % 4;
            end else begin
                m_err[i]    = 1;
                m_sticky[i] = 1;
                if (m_cnt[i] < cnt_max) m_cnt[i]++;
                m_miss[i]++;
                if (m_miss[i] == miss_max) begin
                    m_lock[i] = 0;
                    m_run[i]  = 0;
                    m_miss[i] = 0;
                    m_exp[i]  = (v + 1) % 4;
                end else begin
                    m_exp[i] = (m_exp[i] + 1) % 4;
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] req);
        compared++;
        assert (obs === req)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic check_all(int i, logic l, logic e, logic [31:0] c, logic [31:0] x, logic s);
        string p;
        p = (i == 0) ? "a" : "b";
        check({p, ".locked"}, 32'(l), 32'(m_lock[i]));
        check({p, ".err"}, 32'(e), 32'(m_err[i]));
        check({p, ".err_count"}, c, 32'(m_cnt[i]));
        check({p, ".expected"}, x, 32'(m_exp[i]));
`ifdef COUNT_CHECKER_STICKY_EN
        check({p, ".err_sticky"}, 32'(s), 32'(m_sticky[i]));
`else
        check({p, ".err_sticky"}, 32'(s), 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        mstep(0, 2, 255);
        mstep(1, 15, 3);
        #1;
        check_all(0, a_locked, a_err, 32'(a_cnt), 32'(a_exp), a_sticky);
        check_all(1, b_locked, b_err, 32'(b_cnt), 32'(b_exp), b_sticky);
    endtask

    initial begin
        mreset(0);
        mreset(1);

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, a_locked, a_err, 32'(a_cnt), 32'(a_exp), a_sticky);
        check_all(1, b_locked, b_err, 32'(b_cnt), 32'(b_exp), b_sticky);
        rst = 1'b1;

        // Clean sequence: lock after the 5th sampling edge
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            val = 2'(k);
            step();
            check("lock_timing", 32'(a_locked), (k == 4) ? 32'd1 : 32'd0);
        end
        check("clean_expected", 32'(a_exp), 32'd1);
        check("clean_count", 32'(a_cnt), 32'd0);

        // Single glitch in LOCKED
        val = 2'd2;
        step();
        check("glitch_err", 32'(a_err), 32'd1);
        check("glitch_count", 32'(a_cnt), 32'd1);
        check("glitch_locked", 32'(a_locked), 32'd1);
        for (int k = 2; k < 5; k++) begin
            val = 2'(k);
            step();
            check("resume_err", 32'(a_err), 32'd0);
        end

        // Loss of lock: two wrong samples where 1,2 expected
        val = 2'd3;
        step();
        check("loss_err1", 32'(a_err), 32'd1);
        step();
        check("loss_err2", 32'(a_err), 32'd1);
        check("loss_count", 32'(a_cnt), 32'd3);
        check("loss_unlocked", 32'(a_locked), 32'd0);
        check("loss_expected", 32'(a_exp), 32'd0);
        for (int k = 0; k < 4; k++) begin
            val = 2'(k);
            step();
            check("relock", 32'(a_locked), (k == 3) ? 32'd1 : 32'd0);
        end
        check("sat_count", 32'(b_cnt), 32'd3);
        check("sat_locked", 32'(b_locked), 32'd1);

        // Gated sampling then clear together with en
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            val = 2'($urandom_range(0, 3));
            step();
            check("gated_locked", 32'(a_locked), 32'd1);
        end
        clr = 1'b1;
        en  = 1'b1;
        val = 2'($urandom_range(0, 3));
        step();
        check("clr_locked", 32'(a_locked), 32'd0);
        check("clr_count", 32'(a_cnt), 32'd0);
        check("clr_expected", 32'(a_exp), 32'd0);
        clr = 1'b0;

        // Randomized counting with glitches, gaps and occasional clears
        ctr = 0;
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0)
                val = 2'($urandom_range(0, 3));
            else
                val = 2'(ctr);
            if (en) ctr = (int'(val) + 1) % 4;
            step();
        end

        // Lock cleanly, force one error, then async reset mid-cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            val = 2'(k);
            step();
        end
        val = 2'd0;
        step();
        check("pre_rst_err_a", 32'(a_err), 32'd1);
        check("pre_rst_err_b", 32'(b_err), 32'd1);
`ifdef COUNT_CHECKER_STICKY_EN
        check("pre_rst_sticky", 32'(b_sticky), 32'd1);
`endif
        #3 rst = 1'b0;
        #1;
        mreset(0);
        mreset(1);
        check("async_locked", 32'(a_locked), 32'd0);
        check("async_err", 32'(a_err), 32'd0);
        check("async_count", 32'(b_cnt), 32'd0);
        check("async_expected", 32'(a_exp), 32'd0);
        check("async_sticky", 32'(b_sticky), 32'd0);
        #2 rst = 1'b1;
        en = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/count_checker.md
# count_checker

Receive-side monitor for the free-running modulo-2^WIDTH up-counter value bus (`val`). The monitor samples the bus, acquires lock onto the incrementing sequence, and then flags every sample that breaks the +1 (mod 2^WIDTH) progression. It sits on the consumer side of a counter output in self-test and bring-up builds. It reports lock state, per-sample error pulses and a saturating error count.

## Interface
Parameters:
- `WIDTH`, default 2: width of the monitored counter value.
- `LOCK_CNT`, default 4: number of consecutive correct increments required to enter LOCKED; legal range 1..15.
- `MISS_MAX`, default 2: number of consecutive mismatches in LOCKED that drop the block back to HUNT; legal range 1..15.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Low clears all state immediately.
- `clr`  in  1  synchronous clear. Same effect as reset, applied at the clock edge.
- `en`  in  1  sample strobe; `val` is sampled on edges where `en`=1.
- `val`  in  WIDTH  counter value under test.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse for each mismatching sample taken in LOCKED.
- `err_count`  out  ERR_W  number of errors; saturates at all-ones.
- `expected`  out  WIDTH  next value predicted by the monitor.
- `err_sticky`  out  1  latched error flag; see Configuration.

## Operation
- State variables: `state` (HUNT or LOCKED), `prev_vld`, `run` (4 bits), `miss` (4 bits), `expected`, `err_count`.
- Reset and clear values: state=HUNT, prev_vld=0, run=0, miss=0, expected=0, err_count=0, locked=0, err=0, err_sticky=0.
- `clr` has priority over `en` on the same edge.
- Sample cycles (`en`=1) behave as follows:
  - HUNT with prev_vld=0: expected←val+1, prev_vld←1, no compare.
  - HUNT with prev_vld=1 and val==expected: run←run+1 and expected←val+1. If run+1==LOCK_CNT, then state←LOCKED and run←0.
  - HUNT with prev_vld=1 and val!=expected: run←0, expected←val+1. No `err` pulse and no count in HUNT.
  - LOCKED with val==expected: miss←0, expected←expected+1.
  - LOCKED with val!=expected (flywheel behaviour): `err` pulses, err_count increments (saturating), miss←miss+1, and expected←expected+1 regardless of `val`.
  - If miss+1==MISS_MAX in LOCKED: state←HUNT, run←0, expected←val+1. The `err` pulse for that sample still fires.
- Non-sample cycles (`en`=0): no state change, and `err` is 0.
- Arithmetic: all `expected` arithmetic wraps modulo 2^WIDTH, so 3→0 is a correct increment for WIDTH=2. err_count holds at 2^ERR_W−1 and never wraps.

## Timing
- All outputs are registered. `err`, `locked`, `err_count` and `expected` reflect a sample on the clock edge that takes it (visible in the following cycle). Latency is 1 cycle.
- `err` is high for exactly one cycle per failing sample. Back-to-back failing samples give back-to-back pulses.
- When `rst` is asserted mid-operation, all outputs go to their reset values asynchronously, without waiting for `clk`. Deassertion is synchronised externally.
- Minimum time to lock from reset with clean input at `en`=1 every cycle: LOCK_CNT+1 sample edges.

## Configuration
- `COUNT_CHECKER_STICKY_EN`
  - Defined: `err_sticky` sets on the edge of the first `err` pulse and holds until `rst` or `clr`. It survives a fall back to HUNT.
  - Undefined: the sticky flop is not built and `err_sticky` is tied to 0.

## Test plan
- Reset then clean sequence: `rst` low, then high. Drive `en`=1 and val=0,1,2,3,0,1,… every cycle. Required: locked=1 after the 5th sampling edge, `err` never pulses, err_count=0, and expected tracks val+1.
- Single glitch in LOCKED: after lock, drive val=2 where 1 is expected, then resume 2,3,0. Required: one `err` pulse, err_count=1, locked stays 1 (MISS_MAX=2), and the next samples match.
- Loss of lock: after lock, drive two consecutive wrong values (3,3 where 1,2 are expected). Required: two `err` pulses, err_count=2, then locked=0. Re-lock requires 4 further correct increments.
- Gated sampling and clear: after lock, set `en`=0 for 10 cycles while `val` changes randomly. Required: no change to any output. Then assert `clr` and `en` together. Required: state=HUNT, err_count=0, locked=0, and the sample is ignored.
- Saturation and async reset: with ERR_W=2, force 6 errors in LOCKED using MISS_MAX=15. Required: err_count holds at 3. Pulse `rst` low mid-cycle. Required: all outputs are 0 before the next `clk` edge. With `COUNT_CHECKER_STICKY_EN` defined, `err_sticky`=1 before the reset and 0 after it.
